pcg32_stream_checker: RTL and testbench
=======================================

Name: pcg32_stream_checker

Overview:
- Receive end of a PCG32 random stream.
- Seeded with the same (initstate, initseq) pair as the producing generator, it runs its own PCG32 XSH-RR model in lockstep with the incoming 32-bit words.
- Flags and counts every mismatch.
- Sits downstream of any PCG32 source in self-test and link-integrity paths.

Parameters:
- ERR_W, 16, width of saturating error counter.
- CNT_W, 32, width of wrapping checked-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_valid  in  1  seed request.
- seed_state  in  64  initstate.
- seed_seq  in  63  initseq (stream selector).
- seed_ready  out  1  seed accepted when seed_valid && seed_ready.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream word.
- in_ready  out  1  word consumed when in_valid && in_ready.
- locked  out  1  checker is in CHECK state.
- mismatch  out  1  one-cycle pulse, registered, one cycle after a bad word is consumed.
- expected  out  32  registered expected value of the last consumed word.
- err_count  out  ERR_W  mismatches since last seed.
- word_count  out  CNT_W  words consumed since last seed.

Behaviour:
- Reset is asynchronous active-low. On reset, all registers are 0, FSM = IDLE, and all outputs are 0.
- Arithmetic:
  - MULT = 64'h5851f42d4c957f2d.
  - inc = {seed_seq, 1'b1}.
  - step(s) = s*MULT + inc, mod 2^64.
  - xsh_rr(s) = rotr32(((s>>18)^s)>>27 truncated to 32 bits, s[63:59]).
- FSM:
  - IDLE: seed_ready=1, in_ready=0. A seed handshake latches inc and initstate; s <= 0*MULT+inc = inc; go to SEED_ADD.
  - SEED_ADD: s <= s + initstate; seed_ready=0; go to SEED_STEP.
  - SEED_STEP: s <= step(s); seed_ready=0; clear err_count and word_count; go to CHECK.
  - CHECK: locked=1, seed_ready=1, in_ready = !seed_valid.
    - On a word handshake: expected <= xsh_rr(s); mismatch <= (in_data != xsh_rr(s)); s <= step(s); word_count++.
    - err_count increments on mismatch.
  - FAIL (only with the optional feature): locked=0, in_ready=1 (words drained and ignored), seed_ready=1.
- Latency:
  - Seed handshake to locked=1 is 3 cycles.
  - Word handshake to mismatch/expected/counters updated is 1 cycle.
- Boundaries:
  - A seed handshake in CHECK or FAIL restarts seeding. Seed wins over a simultaneous word; that word is not consumed, because in_ready=0 while seed_valid.
  - seed_valid during SEED_ADD/SEED_STEP is not accepted (seed_ready=0).
  - err_count saturates at all-ones.
  - word_count wraps to 0.
  - mismatch is high for exactly one cycle per bad word; back-to-back bad words give a continuous high.
  - Reset mid-seed or mid-check returns to IDLE immediately.
  - in_valid in IDLE is ignored (in_ready=0).

Optional Feature:
- Macro: PCG32_CHKR_STOP_ON_ERR_EN.
- Defined: the first mismatch moves CHECK to FAIL on the same edge that raises mismatch.
  - In FAIL, the state does not advance and counters freeze.
  - Only a new seed or reset leaves FAIL.
- Undefined: FAIL is not built. Checking continues after errors; the model state keeps advancing per consumed word, so a single corrupted word yields exactly one error.

Decomposition:
- Package pcg32_pkg:
  - MULT constant.
  - FSM state enum {IDLE, SEED_ADD, SEED_STEP, CHECK, FAIL}.
  - Functions pcg32_step(s, inc) and pcg32_xsh_rr(s).
- Sub-module pcg32_xsh_rr_perm: combinational 64→32 output permutation (shift-xor plus variable rotate). It is shared with the generator side.

Test Plan:
- Seed: seed_state=42, seed_seq=54, then feed 0xa15c02b7, 0x7b47f409, 0xba1d3330 → locked 3 cycles after the seed; no mismatch; word_count=3; err_count=0; expected=0xba1d3330.
- Continue with 0x83d2f292 (corrupt; correct value is 0x83d2f293), then 0xbfa4784b, 0xcbed606e:
  - Feature off → one mismatch pulse; err_count=1; word_count=6; later words match.
  - Feature on → FAIL; locked=0; counters stay at err_count=1, word_count=4.
- Assert rst_n low during SEED_ADD → all outputs 0, FSM IDLE, in_ready=0. A new seed (42, 54) then reproduces the 0xa15c02b7 stream.
- In CHECK, assert seed_valid and in_valid together with 0xa15c02b7 pending → word not consumed; checker reseeds; the same word is consumed after locked and matches.
- Force 2^ERR_W+3 bad words (feature off) → err_count saturates at 0xFFFF; mismatch stays high throughout.
- Stall in_valid randomly over 1000 words from a reference PCG32 model → zero mismatches; word_count=1000.

Source files
------------

// File: rtl/pcg32_pkg.sv
// PCG32 XSH-RR constants, checker FSM encoding and reference arithmetic
// shared between the generator and checker sides of the stream.
package pcg32_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned SEQ_W   = 63;
  localparam int unsigned ROT_W   = 5;

  localparam logic [STATE_W-1:0] PCG32_MULT = 64'h5851f42d4c957f2d;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEED_ADD  = 3'd1,
    SEED_STEP = 3'd2,
    CHECK     = 3'd3,
    FAIL      = 3'd4
  } chk_state_e;

  // One LCG advance, modulo 2^64.
  function automatic logic [STATE_W-1:0] pcg32_step(input logic [STATE_W-1:0] s,
                                                     input logic [STATE_W-1:0] inc);
    return s * PCG32_MULT + inc;
  endfunction

  // Output permutation: xorshift-high, then rotate right by the top five state bits.
  function automatic logic [OUT_W-1:0] pcg32_xsh_rr(input logic [STATE_W-1:0] s);
    logic [OUT_W-1:0] xs;
    logic [ROT_W-1:0] rot;
    logic [ROT_W-1:0] lrot;
    xs   = OUT_W'(((s >> 18) ^ s) >> 27);
    rot  = s[STATE_W-1 -: ROT_W];
    lrot = -rot;
    return (xs >> rot) | (xs << lrot);
  endfunction

endpackage

// File: rtl/pcg32_xsh_rr_perm.sv
// Combinational 64->32 PCG32 XSH-RR output permutation; shared with the
// generator side so both ends derive words from state identically.
module pcg32_xsh_rr_perm
  import pcg32_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [OUT_W-1:0]   word_c_o
);

  assign word_c_o = pcg32_xsh_rr(state_i);

endmodule

// File: rtl/pcg32_stream_checker.sv
// PCG32 stream checker: reseeds a local XSH-RR model and compares it word by word
// against an incoming stream. Build macro PCG32_CHKR_STOP_ON_ERR_EN parks it in FAIL on first error.
module pcg32_stream_checker
  import pcg32_pkg::*;
#(
  parameter int unsigned ERR_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_valid_i,
  input  logic [STATE_W-1:0] seed_state_i,
  input  logic [SEQ_W-1:0]   seed_seq_i,
  output logic               seed_ready_o,
  input  logic               in_valid_i,
  input  logic [OUT_W-1:0]   in_data_i,
  output logic               in_ready_o,
  output logic               locked_o,
  output logic               mismatch_o,
  output logic [OUT_W-1:0]   expected_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic [CNT_W-1:0]   word_count_o
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  chk_state_e         state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [STATE_W-1:0] inc_q, inc_d;
  logic [STATE_W-1:0] init_q, init_d;
  logic [OUT_W-1:0]   expected_q, expected_d;
  logic               mismatch_q, mismatch_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_q, locked_d;
  logic               seed_ready_q, seed_ready_d;

  logic [OUT_W-1:0]   perm_word;
  logic               word_bad;
  logic               in_ready_c;

  pcg32_xsh_rr_perm u_perm (
    .state_i  (s_q),
    .word_c_o (perm_word)
  );

  // State register; seed_ready comes up one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      inc_q        <= '0;
      init_q       <= '0;
      expected_q   <= '0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      seed_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      inc_q        <= inc_d;
      init_q       <= init_d;
      expected_q   <= expected_d;
      mismatch_q   <= mismatch_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      seed_ready_q <= seed_ready_d;
    end
  end

  // Next-state, model advance and counter update.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    inc_d      = inc_q;
    init_d     = init_q;
    expected_d = expected_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    word_bad   = (in_data_i != perm_word);

    case (state_q)
      IDLE: ;
      SEED_ADD: begin
        s_d     = s_q + init_q;
        state_d = SEED_STEP;
      end
      SEED_STEP: begin
        s_d     = pcg32_step(s_q, inc_q);
        err_d   = '0;
        cnt_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        in_ready_c = !seed_valid_i;
        if (in_valid_i && in_ready_c) begin
          expected_d = perm_word;
          mismatch_d = word_bad;
          s_d        = pcg32_step(s_q, inc_q);
          cnt_d      = cnt_q + CNT_W'(1);
          if (word_bad && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
          end
`ifdef PCG32_CHKR_STOP_ON_ERR_EN
          if (word_bad) begin
            state_d = FAIL;
          end
`endif
        end
      end
`ifdef PCG32_CHKR_STOP_ON_ERR_EN
      FAIL: begin
        in_ready_c = !seed_valid_i;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A seed handshake overrides everything else; s starts at 0*MULT+inc.
    if (seed_valid_i && seed_ready_q) begin
      inc_d   = {seed_seq_i, 1'b1};
      init_d  = seed_state_i;
      s_d     = {seed_seq_i, 1'b1};
      state_d = SEED_ADD;
    end

    locked_d     = (state_d == CHECK);
    seed_ready_d = (state_d == IDLE) || (state_d == CHECK) || (state_d == FAIL);
  end

  assign seed_ready_o = seed_ready_q;
  assign in_ready_o   = in_ready_c;
  assign locked_o     = locked_q;
  assign mismatch_o   = mismatch_q;
  assign expected_o   = expected_q;
  assign err_count_o  = err_q;
  assign word_count_o = cnt_q;

endmodule

// File: tb/tb_pcg32_stream_checker.sv
// Scoreboard bench for pcg32_stream_checker against a plain-arithmetic PCG32 reference.
module tb_pcg32_stream_checker;

  localparam int unsigned ERR_W = 16;
  localparam int unsigned CNT_W = 32;
  localparam logic [63:0] MULT  = 64'h5851f42d4c957f2d;
  localparam int unsigned N_SAT = (1 << ERR_W) + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             seed_valid = 1'b0;
  logic [63:0]      seed_state = '0;
  logic [62:0]      seed_seq = '0;
  logic             seed_ready_o;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready_o;
  logic             locked_o;
  logic             mismatch_o;
  logic [31:0]      expected_o;
  logic [ERR_W-1:0] err_count_o;
  logic [CNT_W-1:0] word_count_o;

  always #5 clk = ~clk;

  pcg32_stream_checker #(.ERR_W(ERR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_valid_i (seed_valid),
    .seed_state_i (seed_state),
    .seed_seq_i   (seed_seq),
    .seed_ready_o (seed_ready_o),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready_o),
    .locked_o     (locked_o),
    .mismatch_o   (mismatch_o),
    .expected_o   (expected_o),
    .err_count_o  (err_count_o),
    .word_count_o (word_count_o)
  );

  typedef struct {
    logic [31:0]      word;
    logic             mm;
    logic [ERR_W-1:0] err;
    logic [CNT_W-1:0] cnt;
    logic             lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   pend = 1'b0;

  // Reference generator state (PCG reference srandom/next semantics).
  logic [63:0]      m_s = '0;
  logic [63:0]      m_inc = '0;
  logic [31:0]      m_last = '0;
  logic [ERR_W-1:0] m_err = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_failed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_out(input logic [63:0] s);
    logic [31:0] x;
    int r;
    x = 32'(((s >> 18) ^ s) >> 27);
    r = int'(s[63:59]);
    return (x >> r) | (x << ((32 - r) % 32));
  endfunction

  task automatic model_seed(input logic [63:0] st, input logic [62:0] sq);
    m_inc    = {sq, 1'b1};
    m_s      = 64'd0;
    m_s      = m_s * MULT + m_inc;
    m_s      = m_s + st;
    m_s      = m_s * MULT + m_inc;
    m_err    = '0;
    m_cnt    = '0;
    m_failed = 1'b0;
  endtask

  task automatic model_reset();
    m_last   = '0;
    m_err    = '0;
    m_cnt    = '0;
    m_failed = 1'b0;
  endtask

  // Expected response for a word the DUT is about to consume.
  task automatic model_consume(input logic [31:0] d);
    exp_t e;
    logic [31:0] w;
    if (m_failed) begin
      e.word = m_last;
      e.mm   = 1'b0;
    end else begin
      w      = ref_out(m_s);
      m_s    = m_s * MULT + m_inc;
      e.mm   = (d != w);
      m_last = w;
      m_cnt  = m_cnt + 1'b1;
      if (e.mm && (m_err != '1)) m_err = m_err + 1'b1;
`ifdef PCG32_CHKR_STOP_ON_ERR_EN
      if (e.mm) m_failed = 1'b1;
`endif
      e.word = w;
    end
    e.err = m_err;
    e.cnt = m_cnt;
    e.lk  = !m_failed;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per consumed word, one cycle after the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got a consumed word, want none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("mon_expected", 64'(expected_o), 64'(mon_e.word));
          chk("mon_mismatch", 64'(mismatch_o), 64'(mon_e.mm));
          chk("mon_err_count", 64'(err_count_o), 64'(mon_e.err));
          chk("mon_word_count", 64'(word_count_o), 64'(mon_e.cnt));
          chk("mon_locked", 64'(locked_o), 64'(mon_e.lk));
        end
      end else if (rst_n) begin
        chk("mon_mismatch_quiet", 64'(mismatch_o), 64'd0);
      end
      #2;
      pend = rst_n && in_valid && in_ready_o;
    end
  end

  // All tasks below start and end on a falling edge.
  task automatic do_seed(input logic [63:0] st, input logic [62:0] sq);
    int n = 0;
    seed_valid = 1'b1;
    seed_state = st;
    seed_seq   = sq;
    #1;
    chk("in_ready_while_seed_valid", 64'(in_ready_o), 64'd0);
    while (!seed_ready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!seed_ready_o) begin
      chk("seed_ready_timeout", 64'(seed_ready_o), 64'd1);
      seed_valid = 1'b0;
      @(negedge clk);
      return;
    end
    model_seed(st, sq);
    @(negedge clk);
    seed_state = ~st;
    seed_seq   = ~sq;
    #1;
    chk("seed_add_ready", 64'(seed_ready_o), 64'd0);
    chk("seed_add_locked", 64'(locked_o), 64'd0);
    @(negedge clk);
    #1;
    chk("seed_step_ready", 64'(seed_ready_o), 64'd0);
    chk("seed_step_locked", 64'(locked_o), 64'd0);
    seed_valid = 1'b0;
    @(negedge clk);
    chk("lock_latency", 64'(locked_o), 64'd1);
    chk("seed_err_clear", 64'(err_count_o), 64'd0);
    chk("seed_cnt_clear", 64'(word_count_o), 64'd0);
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready_o) begin
      chk("in_ready_timeout", 64'(in_ready_o), 64'd1);
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    model_consume(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, 64'(locked_o), 64'd0);
    chk({tag, "_mismatch"}, 64'(mismatch_o), 64'd0);
    chk({tag, "_expected"}, 64'(expected_o), 64'd0);
    chk({tag, "_err"}, 64'(err_count_o), 64'd0);
    chk({tag, "_cnt"}, 64'(word_count_o), 64'd0);
    chk({tag, "_seed_ready"}, 64'(seed_ready_o), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, then a word offered in IDLE must be ignored.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    chk("idle_in_ready", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    chk("idle_word_count", 64'(word_count_o), 64'd0);
    in_valid = 1'b0;

    // Known-answer stream for (42, 54).
    do_seed(64'd42, 63'd54);
    send_word(32'ha15c02b7);
    send_word(32'h7b47f409);
    send_word(32'hba1d3330);
    chk("kat_expected", 64'(expected_o), 64'hba1d3330);
    chk("kat_word_count", 64'(word_count_o), 64'd3);
    chk("kat_err_count", 64'(err_count_o), 64'd0);

    // One corrupted word, then correct ones.
    send_word(32'h83d2f292);
    send_word(32'hbfa4784b);
    send_word(32'hcbed606e);
`ifdef PCG32_CHKR_STOP_ON_ERR_EN
    chk("corrupt_err_count", 64'(err_count_o), 64'd1);
    chk("corrupt_word_count", 64'(word_count_o), 64'd4);
    chk("corrupt_locked", 64'(locked_o), 64'd0);
`else
    chk("corrupt_err_count", 64'(err_count_o), 64'd1);
    chk("corrupt_word_count", 64'(word_count_o), 64'd6);
    chk("corrupt_locked", 64'(locked_o), 64'd1);
    chk("corrupt_expected", 64'(expected_o), 64'hcbed606e);
`endif

    // Seed and word together: seed wins, word waits and then matches.
    in_valid = 1'b1;
    in_data  = 32'ha15c02b7;
    do_seed(64'd42, 63'd54);
    send_word(32'ha15c02b7);
    chk("collide_word_count", 64'(word_count_o), 64'd1);
    chk("collide_err_count", 64'(err_count_o), 64'd0);
    chk("collide_expected", 64'(expected_o), 64'ha15c02b7);

    // Reset during SEED_ADD, then the stream reproduces.
    seed_valid = 1'b1;
    seed_state = 64'd42;
    seed_seq   = 63'd54;
    #1;
    chk("pre_reset_seed_ready", 64'(seed_ready_o), 64'd1);
    @(negedge clk);
    seed_valid = 1'b0;
    in_valid   = 1'b1;
    rst_n      = 1'b0;
    model_reset();
    #1;
    check_all_zero("midseed_reset");
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    do_seed(64'd42, 63'd54);
    send_word(32'ha15c02b7);
    chk("reseed_first_word", 64'(expected_o), 64'ha15c02b7);
    send_word(ref_out(m_s));
    send_word(ref_out(m_s));

    // Error counter saturation with back-to-back bad words.
    do_seed({$urandom, $urandom}, 63'({$urandom, $urandom}));
    for (int i = 0; i < int'(N_SAT); i++) begin
      send_word(ref_out(m_s) ^ ($urandom | 32'd1));
    end
    chk("sat_err_model", 64'(err_count_o), 64'(m_err));
`ifndef PCG32_CHKR_STOP_ON_ERR_EN
    chk("sat_err_count", 64'(err_count_o), 64'hffff);
    chk("sat_word_count", 64'(word_count_o), 64'(N_SAT));
`endif

    // Randomly stalled clean stream from a random seed.
    do_seed({$urandom, $urandom}, 63'({$urandom, $urandom}));
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_data = $urandom;
        @(negedge clk);
      end
      send_word(ref_out(m_s));
    end
    chk("stream_word_count", 64'(word_count_o), 64'd1000);
    chk("stream_err_count", 64'(err_count_o), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
